// File: rtl/roll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : roll_pkg
// Description : Shared types and board/dice constants for the roll sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package roll_pkg;

    localparam int TILE_W = 4;
    localparam int DICE_W = 3;
    localparam int LFSR_W = 16;

    localparam logic [TILE_W-1:0] LAST_TILE = 4'd9;
    localparam logic [DICE_W-1:0] DICE_MAX  = 3'd6;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ROLL       = 3'd1,
        SHOW       = 3'd2,
        ISSUE      = 3'd3,
        WAIT_START = 3'd4,
        WAIT_DONE  = 3'd5,
        FINISH     = 3'd6
    } state_t;

    // A usable die face is 1..DICE_MAX; 0 and 7 are not faces.
    function automatic logic is_face(input logic [DICE_W-1:0] v);
        return (v >= 3'd1) && (v <= DICE_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dice_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : dice_lfsr
// Description : Free-running 16-bit Galois LFSR; exposes its low dice bits.
// Revision    : 1.0 - initial release
// ============================================================================
module dice_lfsr
    import roll_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DICE_W-1:0] low_bits
);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_MASK : '0);
        end
    end

    assign low_bits = r_lfsr[DICE_W-1:0];

endmodule
`default_nettype wire

// File: rtl/roll_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : roll_sequencer
// Description : Turn controller: rolls a die, then issues one-tile moves.
// Revision    : 1.0 - initial release
// ============================================================================
module roll_sequencer
    import roll_pkg::*;
#(
    parameter int unsigned       SHOW_FRAMES   = 32,
    parameter int unsigned       START_TIMEOUT = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              roll_req,
    input  logic [DICE_W-1:0] debug_dice,
    input  logic [TILE_W-1:0] current_tile,
    input  logic              is_moving,
    output logic              move_trigger,
    output logic [DICE_W-1:0] dice_value,
    output logic [DICE_W-1:0] steps_left,
    output logic              busy,
    output logic              turn_done
);

    localparam int unsigned c_cnt_max = (SHOW_FRAMES > START_TIMEOUT) ? SHOW_FRAMES : START_TIMEOUT;
    localparam int          c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_show_last  = c_cnt_w'(SHOW_FRAMES - 1);
    localparam logic [c_cnt_w-1:0] c_start_last = c_cnt_w'(START_TIMEOUT - 1);

    state_t              r_state;
    logic                r_roll_d;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [DICE_W-1:0]   r_dice;
    logic [DICE_W-1:0]   r_steps;

    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_cnt_w-1:0]  w_cnt_inc;
    logic [DICE_W-1:0]   w_dice_nxt;
    logic [DICE_W-1:0]   w_steps_nxt;
    logic [DICE_W-1:0]   w_steps_dec;
    logic [DICE_W-1:0]   w_lfsr_bits;
    logic                w_roll_edge;
    logic                w_at_goal;

    dice_lfsr #(
        .SEED     (LFSR_SEED)
    ) u_dice_lfsr (
        .clk      (clk),
        .rst      (rst),
        .low_bits (w_lfsr_bits)
    );

    assign w_roll_edge = roll_req & ~r_roll_d;
    assign w_at_goal   = (current_tile == LAST_TILE);
    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_steps_dec = (r_steps == '0) ? r_steps : r_steps - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_roll_d <= 1'b0;
            r_cnt    <= '0;
            r_dice   <= '0;
            r_steps  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_roll_d <= roll_req;
            r_cnt    <= w_cnt_nxt;
            r_dice   <= w_dice_nxt;
            r_steps  <= w_steps_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dice_nxt  = r_dice;
        w_steps_nxt = r_steps;
        case (r_state)
            IDLE: begin
                if (w_roll_edge) w_state_nxt = ROLL;
            end
            ROLL: begin
                // Out-of-range LFSR bits are rejected; retry next cycle.
                if (is_face(debug_dice)) begin
                    w_dice_nxt  = debug_dice;
                    w_steps_nxt = debug_dice;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHOW;
                end else if (is_face(w_lfsr_bits)) begin
                    w_dice_nxt  = w_lfsr_bits;
                    w_steps_nxt = w_lfsr_bits;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHOW;
                end
            end
            SHOW: begin
                // Hold off the first move while a stale move is still in flight.
                if (r_cnt >= c_show_last) begin
                    if (w_at_goal)       w_state_nxt = FINISH;
                    else if (!is_moving) w_state_nxt = ISSUE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (is_moving)                  w_state_nxt = WAIT_DONE;
                else if (r_cnt >= c_start_last) w_state_nxt = FINISH;
                else                            w_cnt_nxt   = w_cnt_inc;
            end
            WAIT_DONE: begin
                if (!is_moving) begin
                    w_steps_nxt = w_steps_dec;
                    if ((w_steps_dec == '0) || w_at_goal) w_state_nxt = FINISH;
                    else                                  w_state_nxt = ISSUE;
                end
            end
            FINISH: begin
                w_steps_nxt = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign move_trigger = (r_state == ISSUE);
    assign turn_done    = (r_state == FINISH);
    assign busy         = (r_state != IDLE);
    assign dice_value   = r_dice;
    assign steps_left   = r_steps;

endmodule
`default_nettype wire

// File: tb/tb_roll_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_roll_sequencer
// Description : Scoreboard bench for roll_sequencer with a player model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_roll_sequencer;
    import roll_pkg::*;

    localparam int unsigned SHOW_F = 8;
    localparam int unsigned TMO    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       roll_req = 1'b0;
    logic [2:0] debug_dice = 3'd0;
    logic [3:0] cur_tile = 4'd0;
    logic       is_moving = 1'b0;
    logic       move_trigger;
    logic [2:0] dice_value;
    logic [2:0] steps_left;
    logic       busy;
    logic       turn_done;

    always #5 clk = ~clk;

    roll_sequencer #(
        .SHOW_FRAMES   (SHOW_F),
        .START_TIMEOUT (TMO),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .roll_req     (roll_req),
        .debug_dice   (debug_dice),
        .current_tile (cur_tile),
        .is_moving    (is_moving),
        .move_trigger (move_trigger),
        .dice_value   (dice_value),
        .steps_left   (steps_left),
        .busy         (busy),
        .turn_done    (turn_done)
    );

    typedef struct {
        int dice;
        bit any;
        bit refuse;
    } turn_t;

    turn_t turn_q[$];
    int    pulse_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    n_turns = 0;
    int    last_pulse_cyc = 0;
    int    face_cnt [8] = '{default: 0};

    int    cfg_tile = 0;
    int    cfg_busy = 4;
    int    cfg_seq = 0;
    bit    cfg_refuse = 1'b0;

    turn_t mon_rec;
    bit    post_chk = 1'b0;
    bit    post_any = 1'b0;
    int    post_dice = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: moves stop at the dice count, the last tile, or a refused start.
    task automatic expect_turn(input int d, input int t, input bit refuse, input bit any);
        turn_t r;
        int    np;
        if (t >= 9)      np = 0;
        else if (refuse) np = 1;
        else             np = (d < 9 - t) ? d : 9 - t;
        for (int k = 0; k < np; k++) pulse_q.push_back(d - k);
        r.dice   = d;
        r.any    = any;
        r.refuse = refuse && (np > 0);
        turn_q.push_back(r);
    endtask

    // Player controller: busy for cfg_busy cycles per move, tile advances on completion.
    initial begin
        int busy_cnt;
        int seen_seq;
        busy_cnt = 0;
        seen_seq = 0;
        forever begin
            @(negedge clk);
            #1;
            if (cfg_seq != seen_seq) begin
                seen_seq = cfg_seq;
                cur_tile = 4'(cfg_tile);
            end
            if (rst) begin
                is_moving = 1'b0;
                busy_cnt  = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    is_moving = 1'b0;
                    if (cur_tile < 4'd9) cur_tile = cur_tile + 4'd1;
                end
            end else if (move_trigger && !cfg_refuse) begin
                is_moving = 1'b1;
                busy_cnt  = cfg_busy;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pulse_q.delete();
            turn_q.delete();
            post_chk = 1'b0;
        end else begin
            if (post_chk) begin
                check("post_busy", 32'(busy), 0);
                check("post_steps", 32'(steps_left), 0);
                if (!post_any) check("post_dice_hold", 32'(dice_value), post_dice);
                post_chk = 1'b0;
            end
            if (move_trigger) begin
                check("pulse_while_moving", 32'(is_moving), 0);
                if (pulse_q.size() == 0) flag("unexpected move_trigger");
                else check("pulse_steps_left", 32'(steps_left), pulse_q.pop_front());
                last_pulse_cyc = cyc;
            end
            if (turn_done) begin
                n_turns++;
                if (turn_q.size() == 0) begin
                    flag("unexpected turn_done");
                end else begin
                    mon_rec = turn_q.pop_front();
                    check("pulses_outstanding", pulse_q.size(), 0);
                    if (mon_rec.any) begin
                        check("lfsr_face_range", 32'(is_face(dice_value)), 1);
                        face_cnt[dice_value]++;
                    end else begin
                        check("dice_value", 32'(dice_value), mon_rec.dice);
                    end
                    if (mon_rec.refuse) check("refuse_latency", cyc - last_pulse_cyc, 1 + TMO);
                    post_chk  = 1'b1;
                    post_any  = mon_rec.any;
                    post_dice = mon_rec.dice;
                end
            end
        end
    end

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget && busy; i++) tick();
        check(name, 32'(busy), 0);
    endtask

    task automatic setup(input int d, input int t, input bit refuse, input int blen);
        debug_dice = 3'(d);
        cfg_tile   = t;
        cfg_busy   = blen;
        cfg_refuse = refuse;
        cfg_seq++;
    endtask

    task automatic run_turn(input int d, input int t, input bit refuse, input int blen, input bit any);
        setup(d, t, refuse, blen);
        expect_turn(d, t, refuse, any);
        tick();
        roll_req = 1'b1;
        tick();
        tick();
        roll_req = 1'b0;
        wait_idle(3000, "turn_end_busy");
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int held;
        bit second;

        repeat (3) tick();
        check("rst_move_trigger", 32'(move_trigger), 0);
        check("rst_dice_value", 32'(dice_value), 0);
        check("rst_steps_left", 32'(steps_left), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_turn_done", 32'(turn_done), 0);
        rst = 1'b0;
        tick();

        // Three full moves from tile 0.
        t0 = n_turns;
        run_turn(3, 0, 1'b0, 40, 1'b0);
        check("d3_turn_count", n_turns - t0, 1);

        // Goal reached after one move.
        run_turn(5, 8, 1'b0, 6, 1'b0);
        check("d5_goal_tile", 32'(cur_tile), 9);

        // Refused move times out.
        run_turn(2, 0, 1'b1, 4, 1'b0);

        // Level held high with a second edge mid-move yields one turn.
        setup(3, 0, 1'b0, 40);
        expect_turn(3, 0, 1'b0, 1'b0);
        t0 = n_turns;
        tick();
        roll_req = 1'b1;
        held = 0;
        second = 1'b0;
        while (held < 200) begin
            tick();
            held++;
            if (!second && is_moving) begin
                repeat (3) tick();
                roll_req = 1'b0;
                tick();
                roll_req = 1'b1;
                held += 4;
                second = 1'b1;
            end
        end
        check("second_edge_seen", 32'(second), 1);
        wait_idle(3000, "held_req_busy");
        roll_req = 1'b0;
        repeat (20) tick();
        check("held_req_one_turn", n_turns - t0, 1);

        // Reset in the middle of a move.
        setup(3, 0, 1'b0, 40);
        expect_turn(3, 0, 1'b0, 1'b0);
        tick();
        roll_req = 1'b1;
        tick();
        roll_req = 1'b0;
        for (int i = 0; i < 200 && !is_moving; i++) tick();
        check("mid_reset_moving", 32'(is_moving), 1);
        repeat (3) tick();
        t0 = n_turns;
        rst = 1'b1;
        tick();
        check("mid_reset_busy", 32'(busy), 0);
        check("mid_reset_trigger", 32'(move_trigger), 0);
        check("mid_reset_steps", 32'(steps_left), 0);
        check("mid_reset_turn_done", 32'(turn_done), 0);
        tick();
        rst = 1'b0;
        repeat (60) tick();
        check("mid_reset_no_turn", n_turns - t0, 0);

        // Randomized forced-dice turns.
        for (int n = 0; n < 40; n++) begin
            run_turn($urandom_range(1, 6), $urandom_range(0, 9),
                     ($urandom_range(0, 5) == 0), $urandom_range(2, 12), 1'b0);
        end

        // LFSR rolls on the goal tile: only the face is of interest.
        for (int n = 0; n < 1000; n++) begin
            run_turn(($urandom_range(0, 1) == 1) ? 0 : 7, 9, 1'b0, 4, 1'b1);
        end
        for (int f = 1; f <= 6; f++) begin
            check($sformatf("face_%0d_seen", f), 32'(face_cnt[f] > 0), 1);
        end

        repeat (5) tick();
        check("queues_drained", pulse_q.size() + turn_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
